sram_rsp_checker: RTL and testbench
===================================

// Module: sram_rsp_checker
// PURPOSE
//  Response checker sitting downstream of the SRAM golden model in the veri-sim sram_model bench.
//  Snoops the request bus, delays each read by the array read latency and compares DUT q against golden q.
//  Counts reads, writes and mismatches, latches the first mismatch and reports a final pass/fail verdict.
//  Single clock; non-synthesised bench logic, written synthesisable so it can also sit in FPGA test harnesses.
// PARAMETERS
//  AW       8    address width (DP = 2**AW = 256 words)
//  DW       32   data width; wstrb width = DW/8
//  RD_LAT   1    cycles from read request to q valid, legal range 1..4
//  MAX_ERR  16   mismatches before the check aborts; 0 = never abort
//  CNT_W    16   width of rd/wr/err counters
// PORTS
//  clk          input   1      bench clock, all logic on rising edge
//  rst          input   1      synchronous active-low reset
//  chk_en       input   1      1 = checking window open; falling edge starts drain
//  cen          input   1      SRAM chip enable, active-low
//  wen          input   1      SRAM write enable, active-low (0 = write, 1 = read)
//  adr          input   AW     request address
//  wstrb        input   DW/8   byte strobes (write counted only if any strobe set)
//  dut_q        input   DW     DUT read data
//  exp_q        input   DW     golden-model read data, same latency as dut_q
//  rd_cnt       output  CNT_W  reads compared
//  wr_cnt       output  CNT_W  writes observed
//  err_cnt      output  CNT_W  mismatches
//  first_vld    output  1      first mismatch captured
//  first_adr    output  AW     address of first mismatch
//  first_exp    output  DW     expected data at first mismatch
//  first_act    output  DW     DUT data at first mismatch
//  done         output  1      verdict valid (sticky until reset)
//  pass         output  1      done & err_cnt==0 & !abort
//  abort        output  1      stopped on MAX_ERR
// BEHAVIOUR
//  Reset (rst==0 at clk edge): all outputs 0, FSM=IDLE, delay line cleared; mid-check reset discards in-flight reads.
//  FSM: IDLE -chk_en=1-> RUN; RUN -chk_en=0-> DRAIN; DRAIN -delay line empty-> DONE;
//       RUN/DRAIN -err_cnt reaches MAX_ERR (MAX_ERR!=0)-> DONE with abort=1; DONE holds until reset.
//  Capture only in RUN: read = cen==0 & wen==1; write = cen==0 & wen==0 & |wstrb. No capture in IDLE/DRAIN/DONE.
//  Read at edge N enters delay line {vld,adr}; compare at edge N+RD_LAT using dut_q/exp_q sampled then.
//  Compare in RUN and DRAIN: mismatch = (dut_q !== exp_q); any X/Z bit in dut_q is a mismatch.
//  On compare: rd_cnt+1; on mismatch err_cnt+1; first mismatch loads first_* and sets first_vld, later ones ignored.
//  All counters saturate at 2**CNT_W-1, never wrap.
//  Back-to-back reads every cycle fully supported (delay line is RD_LAT deep, one entry per cycle).
//  Write and read-compare in same cycle both counted; no read/write hazard filtering (golden model owns ordering).
//  done/pass/abort update on the DONE entry edge; pass and abort mutually exclusive.
//  Mismatch in abort cycle is counted; reads still in flight at abort are dropped, not counted.
// STRUCTURE
//  sram_pkg: AW/DW defaults, FSM state encoding (IDLE=0,RUN=1,DRAIN=2,DONE=3), CNT_W, sat_inc function.
//  Sub-module sram_rd_pipe: RD_LAT-deep valid+address shift register with sync active-low clear and empty flag.
//  Top: FSM, compare, counters, first-mismatch latch.
// TESTING
//  Write 0xA5A5_0000+i to adr 0..3, read back with matching model -> wr_cnt=4, rd_cnt=4, err_cnt=0, pass=1 after drain.
//  Force dut_q=0xDEAD_BEEF on read of adr 0x1E, exp_q=0x0000_001E -> first_adr=0x1E, first_exp=0x1E, first_act=0xDEADBEEF, pass=0.
//  256 back-to-back reads, chk_en dropped same cycle as last read -> last read compared in DRAIN, rd_cnt=256, done 1 cycle later (RD_LAT=1).
//  MAX_ERR=2, three consecutive mismatching reads -> abort=1, err_cnt=2, done=1, third result dropped.
//  dut_q=32'hxxxx_xxxx on a read -> counted as mismatch, err_cnt=1.
//  Assert rst=0 mid-RUN with reads in flight -> next cycle all outputs 0, FSM IDLE; RD_LAT=3 rerun gives clean pass.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared defaults, FSM encoding and saturating-increment helper for the SRAM response checker.
package sram_pkg;

   localparam int unsigned SRAM_AW    = 8;
   localparam int unsigned SRAM_DW    = 32;
   localparam int unsigned SRAM_CNT_W = 16;

   typedef logic [1:0] chk_state_t;

   localparam chk_state_t StIdle  = 2'd0;
   localparam chk_state_t StRun   = 2'd1;
   localparam chk_state_t StDrain = 2'd2;
   localparam chk_state_t StDone  = 2'd3;

   // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max;
      max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max) ? max : val + 32'd1;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency delay line: one {valid, address} entry per cycle, DEPTH stages, sync active-low clear.
module sram_rd_pipe #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          in_vld,
   input  logic [AW-1:0] in_adr,
   output logic          out_vld,
   output logic [AW-1:0] out_adr,
   output logic          empty
);

   logic [DEPTH-1:0] vld_q;
   logic [AW-1:0]    adr_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            adr_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_vld;
         adr_q[0] <= in_adr;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            adr_q[i] <= adr_q[i-1];
         end
      end
   end

   assign out_vld = vld_q[DEPTH-1];
   assign out_adr = adr_q[DEPTH-1];
   assign empty   = ~|vld_q;

endmodule

// File: rtl/sram_rsp_checker.sv
// Snoops SRAM requests, compares DUT vs golden read data after RD_LAT cycles (RD_LAT in 1..4),
// counts reads/writes/mismatches, latches the first mismatch and produces a pass/abort verdict.
module sram_rsp_checker
   import sram_pkg::*;
#(
   parameter int unsigned AW      = SRAM_AW,
   parameter int unsigned DW      = SRAM_DW,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned MAX_ERR = 16,
   parameter int unsigned CNT_W   = SRAM_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic             cen,
   input  logic             wen,
   input  logic [AW-1:0]    adr,
   input  logic [DW/8-1:0]  wstrb,
   input  logic [DW-1:0]    dut_q,
   input  logic [DW-1:0]    exp_q,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             first_vld,
   output logic [AW-1:0]    first_adr,
   output logic [DW-1:0]    first_exp,
   output logic [DW-1:0]    first_act,
   output logic             done,
   output logic             pass,
   output logic             abort
);

   chk_state_t       state_q, state_d;
   logic             rd_req, wr_req, active;
   logic             pipe_vld, pipe_empty, pipe_clr_n;
   logic [AW-1:0]    pipe_adr;
   logic             cmp, mis, abort_now, done_entry;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
   logic             first_vld_q;
   logic [AW-1:0]    first_adr_q;
   logic [DW-1:0]    first_exp_q, first_act_q;
   logic             done_q, pass_q, abort_q;

   assign active = (state_q == StRun) || (state_q == StDrain);
   assign rd_req = (state_q == StRun) && !cen && wen;
   assign wr_req = (state_q == StRun) && !cen && !wen && (|wstrb);
   assign cmp    = active && pipe_vld;
   // Case-inequality so any X/Z on the DUT side counts as a mismatch in simulation.
   assign mis    = cmp && (dut_q !== exp_q);

   always_comb begin
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;
      if (cmp) rd_cnt_d = CNT_W'(sat_inc(32'(rd_cnt_q), CNT_W));
      if (wr_req) wr_cnt_d = CNT_W'(sat_inc(32'(wr_cnt_q), CNT_W));
      if (mis) err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
   end

   assign abort_now = mis && (MAX_ERR != 0) && (32'(err_cnt_d) >= MAX_ERR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (chk_en) state_d = StRun;
         StRun: begin
            if (abort_now) state_d = StDone;
            else if (!chk_en) state_d = StDrain;
         end
         StDrain: if (abort_now || pipe_empty) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   assign done_entry = (state_q != StDone) && (state_d == StDone);

   // Abort flushes the delay line so reads still in flight are never counted.
   assign pipe_clr_n = rst && !abort_now;

   sram_rd_pipe #(
      .AW    (AW),
      .DEPTH (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .clr_n   (pipe_clr_n),
      .in_vld  (rd_req),
      .in_adr  (adr),
      .out_vld (pipe_vld),
      .out_adr (pipe_adr),
      .empty   (pipe_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         err_cnt_q   <= '0;
         first_vld_q <= 1'b0;
         first_adr_q <= '0;
         first_exp_q <= '0;
         first_act_q <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
         if (mis && !first_vld_q) begin
            first_vld_q <= 1'b1;
            first_adr_q <= pipe_adr;
            first_exp_q <= exp_q;
            first_act_q <= dut_q;
         end
         if (done_entry) begin
            done_q  <= 1'b1;
            abort_q <= abort_now;
            pass_q  <= !abort_now && (err_cnt_d == '0);
         end
      end
   end

   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign first_vld = first_vld_q;
   assign first_adr = first_adr_q;
   assign first_exp = first_exp_q;
   assign first_act = first_act_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_sram_rsp_checker.sv
// Bench for sram_rsp_checker: two instances (RD_LAT=1/MAX_ERR=2 and RD_LAT=3/MAX_ERR=0) on one bus,
// checked against a transaction-level model built from in-flight read queues.
module tb_sram_rsp_checker;

   localparam int LAT0 = 1;
   localparam int ME0  = 2;
   localparam int LAT1 = 3;
   localparam int ME1  = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic       chk_en, cen, wen;
   logic [7:0] adr;
   logic [3:0] wstrb;
   logic [31:0] cur_e, cur_a;
   logic        cur_x;

   logic [1:0][31:0] dq, eq;
   logic [1:0][15:0] rd_w, wr_w, err_w;
   logic [1:0]       fv_w, done_w, pass_w, abort_w;
   logic [1:0][7:0]  fa_w;
   logic [1:0][31:0] fe_w, fact_w;

   // Golden-model side of the bench: each request's data rides a latency line to the checkers.
   typedef struct packed {
      logic [31:0] e;
      logic [31:0] a;
      logic        x;
   } hist_t;
   hist_t hist [4];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      hist[0] <= '{e: cur_e, a: cur_a, x: cur_x};
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
   end

   assign eq[0] = hist[LAT0-1].e;
   assign dq[0] = hist[LAT0-1].x ? 32'hxxxx_xxxx : hist[LAT0-1].a;
   assign eq[1] = hist[LAT1-1].e;
   assign dq[1] = hist[LAT1-1].x ? 32'hxxxx_xxxx : hist[LAT1-1].a;

   sram_rsp_checker #(
      .AW(8), .DW(32), .RD_LAT(LAT0), .MAX_ERR(ME0), .CNT_W(16)
   ) u_dut0 (
      .clk(clk), .rst(rst), .chk_en(chk_en), .cen(cen), .wen(wen), .adr(adr), .wstrb(wstrb),
      .dut_q(dq[0]), .exp_q(eq[0]), .rd_cnt(rd_w[0]), .wr_cnt(wr_w[0]), .err_cnt(err_w[0]),
      .first_vld(fv_w[0]), .first_adr(fa_w[0]), .first_exp(fe_w[0]), .first_act(fact_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .abort(abort_w[0])
   );

   sram_rsp_checker #(
      .AW(8), .DW(32), .RD_LAT(LAT1), .MAX_ERR(ME1), .CNT_W(16)
   ) u_dut1 (
      .clk(clk), .rst(rst), .chk_en(chk_en), .cen(cen), .wen(wen), .adr(adr), .wstrb(wstrb),
      .dut_q(dq[1]), .exp_q(eq[1]), .rd_cnt(rd_w[1]), .wr_cnt(wr_w[1]), .err_cnt(err_w[1]),
      .first_vld(fv_w[1]), .first_adr(fa_w[1]), .first_exp(fe_w[1]), .first_act(fact_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .abort(abort_w[1])
   );

   // ---------------- reference model ----------------
   typedef struct {
      int          k;
      int          due;
      logic [7:0]  adr;
      logic [31:0] e;
      logic [31:0] a;
      bit          x;
   } pend_t;

   pend_t       pq[$];
   int          t;
   int unsigned m_rd[2], m_wr[2], m_err[2];
   int          m_st[2];  // 0 not opened, 1 window open, 2 window closed
   bit          m_fv[2], m_fx[2], m_done[2], m_pass[2], m_abort[2];
   logic [7:0]  m_fa[2];
   logic [31:0] m_fe[2], m_fact[2];

   int checks = 0;
   int errors = 0;

   task automatic model_reset();
      pq.delete();
      for (int k = 0; k < 2; k++) begin
         m_rd[k] = 0; m_wr[k] = 0; m_err[k] = 0; m_st[k] = 0;
         m_fv[k] = 0; m_fx[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_abort[k] = 0;
         m_fa[k] = '0; m_fe[k] = '0; m_fact[k] = '0;
      end
   endtask

   task automatic model_edge(input bit en, input bit c, input bit w, input logic [7:0] a,
                             input logic [3:0] s, input logic [31:0] e, input logic [31:0] act,
                             input bit x);
      for (int k = 0; k < 2; k++) begin
         int  lat  = (k == 0) ? LAT0 : LAT1;
         int  maxe = (k == 0) ? ME0 : ME1;
         bit  inflight = 0;
         int  idx = -1;
         foreach (pq[i]) if (pq[i].k == k) begin
            inflight = 1;
            if (idx < 0) idx = i;
         end
         if (!m_done[k] && m_st[k] != 0 && idx >= 0 && pq[idx].due == t) begin
            pend_t p = pq[idx];
            pq.delete(idx);
            m_rd[k]++;
            if (p.x || p.a != p.e) begin
               m_err[k]++;
               if (!m_fv[k]) begin
                  m_fv[k] = 1; m_fa[k] = p.adr; m_fe[k] = p.e; m_fact[k] = p.a; m_fx[k] = p.x;
               end
               if (maxe != 0 && m_err[k] >= maxe) begin
                  m_done[k] = 1; m_abort[k] = 1;
                  for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].k == k) pq.delete(i);
               end
            end
         end
         if (!m_done[k] && m_st[k] == 1) begin
            if (!c && w) pq.push_back('{k: k, due: t + lat, adr: a, e: e, a: act, x: x});
            if (!c && !w && s != 0) m_wr[k]++;
         end
         if (!m_done[k]) begin
            if (m_st[k] == 0 && en) m_st[k] = 1;
            else if (m_st[k] == 1 && !en) m_st[k] = 2;
            else if (m_st[k] == 2 && !inflight) begin
               m_done[k] = 1;
               m_pass[k] = (m_err[k] == 0);
            end
         end
      end
      t++;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input int k, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, ".rd_cnt"},    k, 64'(rd_w[k]),    64'(m_rd[k]));
         check({tag, ".wr_cnt"},    k, 64'(wr_w[k]),    64'(m_wr[k]));
         check({tag, ".err_cnt"},   k, 64'(err_w[k]),   64'(m_err[k]));
         check({tag, ".first_vld"}, k, 64'(fv_w[k]),    64'(m_fv[k]));
         check({tag, ".first_adr"}, k, 64'(fa_w[k]),    64'(m_fa[k]));
         check({tag, ".first_exp"}, k, 64'(fe_w[k]),    64'(m_fe[k]));
         if (!m_fx[k]) check({tag, ".first_act"}, k, 64'(fact_w[k]), 64'(m_fact[k]));
         check({tag, ".done"},      k, 64'(done_w[k]),  64'(m_done[k]));
         check({tag, ".pass"},      k, 64'(pass_w[k]),  64'(m_pass[k]));
         check({tag, ".abort"},     k, 64'(abort_w[k]), 64'(m_abort[k]));
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input bit en, input bit c, input bit w, input logic [7:0] a,
                      input logic [3:0] s, input logic [31:0] e, input logic [31:0] act,
                      input bit x);
      chk_en = en; cen = c; wen = w; adr = a; wstrb = s;
      cur_e = e; cur_a = act; cur_x = x;
      @(posedge clk);
      model_edge(en, c, w, a, s, e, act, x);
      #1;
   endtask

   task automatic idle(input bit en, input int n);
      for (int i = 0; i < n; i++) cyc(en, 1'b1, 1'b1, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0; chk_en = 1'b0; cen = 1'b1; wen = 1'b1; adr = '0; wstrb = '0;
      cur_e = '0; cur_a = '0; cur_x = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      t = 0;
      do_reset();
      check_all("reset");

      // Writes then matching read-back.
      idle(1'b1, 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i), 4'hF, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         d = 32'hA5A5_0000 + 32'(i);
         cyc(1'b1, 1'b0, 1'b1, 8'(i), 4'h0, d, d, 1'b0);
      end
      idle(1'b0, 6);
      check_all("wr_rd");
      check("spec.wr_rd.pass", 1, 64'(pass_w[1]), 64'd1);

      // Single forced mismatch.
      do_reset();
      idle(1'b1, 1);
      cyc(1'b1, 1'b0, 1'b1, 8'h1E, 4'h0, 32'h0000_001E, 32'hDEAD_BEEF, 1'b0);
      idle(1'b0, 6);
      check_all("mismatch");
      check("spec.mismatch.first_act", 0, 64'(fact_w[0]), 64'hDEAD_BEEF);

      // 256 back-to-back reads, window closes with the last one.
      do_reset();
      idle(1'b1, 1);
      for (int i = 0; i < 256; i++) begin
         d = $urandom;
         cyc((i != 255), 1'b0, 1'b1, 8'(i), 4'h0, d, d, 1'b0);
      end
      check_all("b2b.close");
      idle(1'b0, 1);
      check_all("b2b.drain");
      idle(1'b0, 1);
      check_all("b2b.done");
      check("spec.b2b.rd_cnt", 0, 64'(rd_w[0]), 64'd256);
      idle(1'b0, 3);
      check_all("b2b.final");

      // Three consecutive mismatches: instance 0 aborts at two.
      do_reset();
      idle(1'b1, 1);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         cyc(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 4'h0, d, ~d, 1'b0);
      end
      idle(1'b0, 6);
      check_all("abort");

      // Unknown DUT data.
      do_reset();
      idle(1'b1, 1);
      cyc(1'b1, 1'b0, 1'b1, 8'h33, 4'h0, 32'h5A5A_1234, 32'h5A5A_1234, 1'b1);
      idle(1'b0, 6);
      check_all("xdata");

      // Reset with reads in flight, then a clean rerun.
      do_reset();
      idle(1'b1, 1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i), 4'h0, 32'h1, 32'h2, 1'b0);
      do_reset();
      check_all("mid_rst");
      idle(1'b1, 1);
      for (int i = 0; i < 12; i++) begin
         d = $urandom;
         cyc(1'b1, 1'b0, (i % 3 != 0), 8'($urandom), 4'($urandom_range(1, 15)), d, d, 1'b0);
      end
      idle(1'b0, 8);
      check_all("rerun");

      // Randomized windows with sparse mismatches.
      for (int r = 0; r < 4; r++) begin
         int n, close_at;
         do_reset();
         idle(1'b1, 1);
         n = $urandom_range(20, 60);
         close_at = $urandom_range(5, n);
         for (int i = 0; i < n; i++) begin
            int unsigned op = $urandom_range(0, 3);
            logic [31:0] act;
            d = $urandom;
            act = ($urandom_range(0, 9) == 0) ? (d ^ (32'd1 << $urandom_range(0, 31))) : d;
            case (op)
               0: cyc((i < close_at), 1'b1, 1'b1, 8'($urandom), 4'h0, d, d, 1'b0);
               1: cyc((i < close_at), 1'b0, 1'b1, 8'($urandom), 4'h0, d, act, 1'b0);
               2: cyc((i < close_at), 1'b0, 1'b0, 8'($urandom), 4'($urandom_range(1, 15)),
                      d, d, 1'b0);
               default: cyc((i < close_at), 1'b0, 1'b0, 8'($urandom), 4'h0, d, d, 1'b0);
            endcase
         end
         idle(1'b0, 8);
         check_all($sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
